// File: rtl/gpio_mux_pkg.sv
// Shared types and width helpers for the registered GPIO pin multiplexer.
package gpio_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } pin_state_e;

    // Never returns 0 so a degenerate count still yields a legal vector width.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned pin_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam logic RST_OEB = 1'b1;
    localparam logic RST_OUT = 1'b0;

endpackage

// File: rtl/gpio_pin_switch.sv
// One pad's source switch: active/target select, gap FSM and the registered pad drive.
module gpio_pin_switch
    import gpio_mux_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 13,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned SEL_W      = sel_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_commit,
    input  logic [SEL_W-1:0]   i_shadow_sel,
    input  logic [NUM_SRC-1:0] i_src_oeb,
    input  logic [NUM_SRC-1:0] i_src_out,
    output logic [SEL_W-1:0]   o_active_sel,
    output logic               o_oeb,
    output logic               o_out,
    output logic               o_busy
);

    localparam int unsigned CNT_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    pin_state_e       r_state;
    pin_state_e       w_state_nxt;
    logic [SEL_W-1:0] r_active;
    logic [SEL_W-1:0] r_target;
    logic [SEL_W-1:0] w_active_nxt;
    logic [SEL_W-1:0] w_target_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_switch;
    logic             w_force;
    logic             r_oeb;
    logic             r_out;

    assign w_switch = i_commit && (i_shadow_sel != r_active);

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_force      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_switch) begin
                    if (GAP_CYCLES == 0) begin
                        w_active_nxt = i_shadow_sel;
                    end else begin
                        w_state_nxt  = GAP;
                        w_target_nxt = i_shadow_sel;
                        w_cnt_nxt    = CNT_W'(GAP_CYCLES);
                        w_force      = 1'b1;
                    end
                end
            end
            GAP: begin
                // The exit edge already samples the new source, so the pad is
                // forced for exactly GAP_CYCLES registered cycles.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = r_target;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_force   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= IDLE;
            r_active <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_oeb    <= RST_OEB;
            r_out    <= RST_OUT;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_oeb    <= w_force ? 1'b1 : i_src_oeb[w_active_nxt];
            r_out    <= w_force ? 1'b0 : i_src_out[w_active_nxt];
        end
    end

    assign o_active_sel = r_active;
    assign o_oeb        = r_oeb;
    assign o_out        = r_out;
    assign o_busy       = (r_state == GAP);

endmodule

// File: rtl/gpio_pin_mux_ctrl.sv
// Registered GPIO alternate-function mux: shadow selects, atomic commit, per-pin tri-state gap.
module gpio_pin_mux_ctrl
    import gpio_mux_pkg::*;
#(
    parameter int unsigned NUM_PINS   = 38,
    parameter int unsigned NUM_SRC    = 13,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned SEL_W      = sel_width(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [NUM_SRC-1:0][NUM_PINS-1:0]  io_oeb,
    input  logic [NUM_SRC-1:0][NUM_PINS-1:0]  io_out,
    input  logic                              cfg_we,
    input  logic [pin_width(NUM_PINS)-1:0]    cfg_pin,
    input  logic [SEL_W-1:0]                  cfg_sel,
    input  logic                              cfg_commit,
    output logic [SEL_W-1:0]                  cfg_rd_active,
    output logic [SEL_W-1:0]                  cfg_rd_shadow,
    output logic                              cfg_busy,
    output logic                              cfg_err,
    output logic [NUM_PINS-1:0]               muxxed_io_oeb,
    output logic [NUM_PINS-1:0]               muxxed_io_out
);

    localparam int unsigned    PIN_W   = pin_width(NUM_PINS);
    localparam logic [PIN_W:0] PIN_LIM = (PIN_W + 1)'(NUM_PINS);
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(NUM_SRC);

    logic [SEL_W-1:0]    r_shadow [NUM_PINS];
    logic [SEL_W-1:0]    w_active [NUM_PINS];
    logic [NUM_PINS-1:0] w_busy;
    logic [NUM_PINS-1:0] w_pin_oeb;
    logic [NUM_PINS-1:0] w_pin_out;
    logic                w_pin_ok;
    logic                w_sel_ok;
    logic                w_wr_ok;
    logic                w_commit_go;
    logic                r_err;

    assign w_pin_ok    = ({1'b0, cfg_pin} < PIN_LIM);
    assign w_sel_ok    = ({1'b0, cfg_sel} < SEL_LIM);
    assign w_wr_ok     = cfg_we && w_pin_ok && w_sel_ok;
    assign w_commit_go = cfg_commit && !cfg_busy;

    // Pins sample r_shadow at the commit edge, so a same-cycle write only
    // reaches the following commit.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < NUM_PINS; i++) begin
                r_shadow[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_err <= (cfg_we && !(w_pin_ok && w_sel_ok)) || (cfg_commit && cfg_busy);
            if (w_wr_ok) begin
                r_shadow[cfg_pin] <= cfg_sel;
            end
        end
    end

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [NUM_SRC-1:0] w_src_oeb;
        logic [NUM_SRC-1:0] w_src_out;

        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            assign w_src_oeb[s] = io_oeb[s][p];
            assign w_src_out[s] = io_out[s][p];
        end

        gpio_pin_switch #(
            .NUM_SRC    (NUM_SRC),
            .GAP_CYCLES (GAP_CYCLES),
            .SEL_W      (SEL_W)
        ) u_switch (
            .clk          (clk),
            .nrst         (nrst),
            .i_commit     (w_commit_go),
            .i_shadow_sel (r_shadow[p]),
            .i_src_oeb    (w_src_oeb),
            .i_src_out    (w_src_out),
            .o_active_sel (w_active[p]),
            .o_oeb        (w_pin_oeb[p]),
            .o_out        (w_pin_out[p]),
            .o_busy       (w_busy[p])
        );
    end

    assign cfg_rd_active = w_pin_ok ? w_active[cfg_pin] : '0;
    assign cfg_rd_shadow = w_pin_ok ? r_shadow[cfg_pin] : '0;
    assign cfg_busy      = |w_busy;
    assign cfg_err       = r_err;
    assign muxxed_io_oeb = w_pin_oeb;
    assign muxxed_io_out = w_pin_out;

endmodule

// File: tb/tb_gpio_pin_mux_ctrl.sv
// Self-checking bench for gpio_pin_mux_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_gpio_pin_mux_ctrl;

    localparam int unsigned NP  = 38;
    localparam int unsigned NS  = 13;
    localparam int unsigned GAP = 2;
    localparam int unsigned SW  = 4;
    localparam int unsigned PW  = 6;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [NS-1:0][NP-1:0] io_oeb;
    logic [NS-1:0][NP-1:0] io_out;
    logic                  cfg_we;
    logic [PW-1:0]         cfg_pin;
    logic [SW-1:0]         cfg_sel;
    logic                  cfg_commit;
    logic [SW-1:0]         cfg_rd_active;
    logic [SW-1:0]         cfg_rd_shadow;
    logic                  cfg_busy;
    logic                  cfg_err;
    logic [NP-1:0]         muxxed_io_oeb;
    logic [NP-1:0]         muxxed_io_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpio_pin_mux_ctrl #(
        .NUM_PINS   (NP),
        .NUM_SRC    (NS),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .io_oeb        (io_oeb),
        .io_out        (io_out),
        .cfg_we        (cfg_we),
        .cfg_pin       (cfg_pin),
        .cfg_sel       (cfg_sel),
        .cfg_commit    (cfg_commit),
        .cfg_rd_active (cfg_rd_active),
        .cfg_rd_shadow (cfg_rd_shadow),
        .cfg_busy      (cfg_busy),
        .cfg_err       (cfg_err),
        .muxxed_io_oeb (muxxed_io_oeb),
        .muxxed_io_out (muxxed_io_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: each pin has a countdown of forced cycles still to show; when it
    // reaches zero the latched target becomes the active source.
    int            m_shadow [NP];
    int            m_active [NP];
    int            m_target [NP];
    int            m_rem    [NP];
    logic [NP-1:0] e_oeb;
    logic [NP-1:0] e_out;
    logic          e_err;
    logic          e_busy;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        bit busy_pre;
        busy_pre = 1'b0;
        if (!nrst) begin
            for (int p = 0; p < NP; p++) begin
                m_shadow[p] = 0;
                m_active[p] = 0;
                m_target[p] = 0;
                m_rem[p]    = 0;
            end
            e_oeb = '1;
            e_out = '0;
            e_err = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) if (m_rem[p] > 0) busy_pre = 1'b1;
            e_err = (cfg_we && (int'(cfg_pin) >= NP || int'(cfg_sel) >= NS)) || (cfg_commit && busy_pre);
            for (int p = 0; p < NP; p++) begin
                if (m_rem[p] > 0) begin
                    m_rem[p]--;
                    if (m_rem[p] == 0) m_active[p] = m_target[p];
                end
            end
            if (cfg_commit && !busy_pre) begin
                for (int p = 0; p < NP; p++) begin
                    if (m_shadow[p] != m_active[p]) begin
                        if (GAP == 0) m_active[p] = m_shadow[p];
                        else begin
                            m_rem[p]    = GAP;
                            m_target[p] = m_shadow[p];
                        end
                    end
                end
            end
            if (cfg_we && int'(cfg_pin) < NP && int'(cfg_sel) < NS) m_shadow[int'(cfg_pin)] = int'(cfg_sel);
            for (int p = 0; p < NP; p++) begin
                e_oeb[p] = (m_rem[p] > 0) ? 1'b1 : io_oeb[m_active[p]][p];
                e_out[p] = (m_rem[p] > 0) ? 1'b0 : io_out[m_active[p]][p];
            end
        end
        e_busy = 1'b0;
        for (int p = 0; p < NP; p++) if (m_rem[p] > 0) e_busy = 1'b1;
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        int ea;
        int es;
        if (m_valid) begin
            ea = (int'(cfg_pin) < NP) ? m_active[int'(cfg_pin)] : 0;
            es = (int'(cfg_pin) < NP) ? m_shadow[int'(cfg_pin)] : 0;
            chk("model_oeb", 64'(muxxed_io_oeb), 64'(e_oeb));
            chk("model_out", 64'(muxxed_io_out), 64'(e_out));
            chk("model_busy", 64'(cfg_busy), 64'(e_busy));
            chk("model_err", 64'(cfg_err), 64'(e_err));
            chk("model_rd_active", 64'(cfg_rd_active), 64'(ea));
            chk("model_rd_shadow", 64'(cfg_rd_shadow), 64'(es));
        end
    end

    initial begin
        logic [NP-1:0] m5;
        int bc;
        m5 = '0;
        m5[5] = 1'b1;
        nrst = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_pin = '0; cfg_sel = '0;
        io_out = '1; io_oeb = '0;

        // Reset while every source drives 1 with outputs enabled.
        step(3);
        chk("rst_oeb", 64'(muxxed_io_oeb), 64'({NP{1'b1}}));
        chk("rst_out", 64'(muxxed_io_out), 64'(0));
        chk("rst_busy", 64'(cfg_busy), 64'(0));
        chk("rst_err", 64'(cfg_err), 64'(0));

        for (int s = 0; s < NS; s++) begin
            for (int p = 0; p < NP; p++) begin
                io_out[s][p] = ((s + p) % 3 == 0);
                io_oeb[s][p] = ((s + 2 * p) % 5 == 0);
            end
        end
        io_out[0][5] = 1'b0; io_oeb[0][5] = 1'b0;
        io_out[3][5] = 1'b1; io_oeb[3][5] = 1'b0;

        nrst = 1'b1;
        step(1);
        chk("rel_out", 64'(muxxed_io_out), 64'(io_out[0]));
        chk("rel_oeb", 64'(muxxed_io_oeb), 64'(io_oeb[0]));
        chk("rel_pin0_out", 64'(muxxed_io_out[0]), 64'(1));
        chk("rel_pin0_oeb", 64'(muxxed_io_oeb[0]), 64'(1));
        chk("rel_pin5_oeb", 64'(muxxed_io_oeb[5]), 64'(0));

        // Basic switch: pin5 -> source 3.
        cfg_we = 1'b1; cfg_pin = 6'd5; cfg_sel = 4'd3;
        step(1);
        cfg_we = 1'b0;
        chk("stage5_shadow", 64'(cfg_rd_shadow), 64'(3));
        chk("stage5_active", 64'(cfg_rd_active), 64'(0));
        cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
        chk("gap1_oeb5", 64'(muxxed_io_oeb[5]), 64'(1));
        chk("gap1_out5", 64'(muxxed_io_out[5]), 64'(0));
        chk("gap1_busy", 64'(cfg_busy), 64'(1));
        chk("gap1_others", 64'(muxxed_io_out & ~m5), 64'(io_out[0] & ~m5));
        step(1);
        chk("gap2_oeb5", 64'(muxxed_io_oeb[5]), 64'(1));
        chk("gap2_busy", 64'(cfg_busy), 64'(1));
        step(1);
        chk("sw_oeb5", 64'(muxxed_io_oeb[5]), 64'(0));
        chk("sw_out5", 64'(muxxed_io_out[5]), 64'(1));
        chk("sw_busy", 64'(cfg_busy), 64'(0));
        chk("sw_active5", 64'(cfg_rd_active), 64'(3));
        chk("sw_others_oeb", 64'(muxxed_io_oeb & ~m5), 64'(io_oeb[0] & ~m5));
        io_out[3][5] = 1'b0;
        step(1);
        chk("follow_out5", 64'(muxxed_io_out[5]), 64'(0));
        io_out[3][5] = 1'b1;
        step(1);

        // Rejected writes.
        cfg_we = 1'b1; cfg_pin = 6'd38; cfg_sel = 4'd1;
        step(1);
        cfg_we = 1'b0;
        chk("err_pin", 64'(cfg_err), 64'(1));
        chk("rd_pin38", 64'(cfg_rd_shadow), 64'(0));
        step(1);
        chk("err_clear", 64'(cfg_err), 64'(0));
        cfg_we = 1'b1; cfg_pin = 6'd5; cfg_sel = 4'd13;
        step(1);
        cfg_we = 1'b0;
        chk("err_sel", 64'(cfg_err), 64'(1));
        chk("err_sel_shadow", 64'(cfg_rd_shadow), 64'(3));

        // Commit while busy: pin5 back to source 0, second commit rejected.
        cfg_we = 1'b1; cfg_sel = 4'd0;
        step(1);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        step(1);
        step(1);
        cfg_commit = 1'b0;
        chk("busy_commit_err", 64'(cfg_err), 64'(1));
        chk("busy_commit_busy", 64'(cfg_busy), 64'(1));
        chk("busy_commit_oeb5", 64'(muxxed_io_oeb[5]), 64'(1));
        step(1);
        chk("busy_commit_done", 64'(cfg_busy), 64'(0));
        chk("busy_commit_err0", 64'(cfg_err), 64'(0));
        chk("busy_commit_sw", 64'(muxxed_io_oeb[5]), 64'(0));

        // Same-cycle write + commit uses the pre-write shadow.
        cfg_we = 1'b1; cfg_pin = 6'd2; cfg_sel = 4'd1;
        step(1);
        cfg_sel = 4'd4; cfg_commit = 1'b1;
        step(1);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        step(2);
        chk("same_active", 64'(cfg_rd_active), 64'(1));
        chk("same_shadow", 64'(cfg_rd_shadow), 64'(4));
        cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
        step(2);
        chk("same_second", 64'(cfg_rd_active), 64'(4));
        chk("same_out2", 64'(muxxed_io_out[2]), 64'(io_out[4][2]));

        // Multi-pin atomic commit.
        cfg_we = 1'b1; cfg_pin = 6'd0;  cfg_sel = 4'd1;  step(1);
        cfg_pin = 6'd17; cfg_sel = 4'd7;  step(1);
        cfg_pin = 6'd37; cfg_sel = 4'd12; step(1);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
        chk("multi_gap_oeb", 64'({muxxed_io_oeb[37], muxxed_io_oeb[17], muxxed_io_oeb[0]}), 64'(3'b111));
        bc = 0;
        for (int k = 0; k < 10; k++) begin
            if (cfg_busy) bc++;
            step(1);
        end
        chk("multi_busy_len", 64'(bc), 64'(GAP));
        cfg_pin = 6'd17;
        #1;
        chk("multi_active17", 64'(cfg_rd_active), 64'(7));
        chk("multi_out37", 64'(muxxed_io_out[37]), 64'(io_out[12][37]));

        // Reset in the middle of a gap.
        cfg_we = 1'b1; cfg_pin = 6'd10; cfg_sel = 4'd5;
        step(1);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        step(1);
        cfg_commit = 1'b0;
        chk("midgap_busy", 64'(cfg_busy), 64'(1));
        nrst = 1'b0;
        step(1);
        chk("midrst_oeb", 64'(muxxed_io_oeb), 64'({NP{1'b1}}));
        chk("midrst_out", 64'(muxxed_io_out), 64'(0));
        chk("midrst_busy", 64'(cfg_busy), 64'(0));
        for (int p = 0; p < NP; p++) begin
            cfg_pin = PW'(p);
            #1;
            chk("midrst_active", 64'(cfg_rd_active), 64'(0));
        end
        nrst = 1'b1;
        step(3);
        cfg_pin = 6'd10;
        #1;
        chk("midrst_dropped", 64'(cfg_rd_active), 64'(0));
        chk("midrst_shadow", 64'(cfg_rd_shadow), 64'(0));

        // Mixed traffic, including illegal indices and occasional reset.
        repeat (300) begin
            nrst       = ($urandom_range(63, 0) != 0);
            cfg_we     = ($urandom_range(2, 0) == 0);
            cfg_pin    = PW'($urandom_range(39, 0));
            cfg_sel    = SW'($urandom_range(13, 0));
            cfg_commit = ($urandom_range(4, 0) == 0);
            for (int s = 0; s < NS; s++) begin
                io_out[s] = NP'({$urandom(), $urandom()});
                io_oeb[s] = NP'({$urandom(), $urandom()});
            end
            step(1);
        end
        nrst = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
